// File: rtl/unit_normalize_seq.sv
// unit_normalize_seq
// Iterative, handshaked normaliser for the FPU add/sub datapath. It sits
// between the mantissa ALU and the rounding stage.
//
// It resolves, in priority order:
//   - a special operand (all-ones exponent), passed through unchanged;
//   - a carry right-shift, which may overflow;
//   - a zero mantissa;
//   - an already normalised mantissa;
//   - otherwise, a left normalisation of up to SHIFT_STEP positions per
//     cycle, which flushes to zero if the exponent would reach zero.
//
// Ports:
//   i_clk, i_rst         clock; synchronous active-high reset
//   i_valid, o_in_ready  input handshake (o_in_ready is high only in IDLE)
//   i_aos_alu, i_c_alu   add/sub flag and ALU carry-out (carry used only on add)
//   i_exp, i_mant        raw exponent and mantissa
//                        (mantissa bit MANT_W-1 is the hidden bit, bit 0 is sticky)
//   o_valid, i_out_ready output handshake; results are held while stalled
//   o_exp, o_mant        normalised result
//   o_ov_fl, o_un_fl     overflow / underflow flags, valid with o_valid
//
// Optional build macro UNIT_NORM_EVT_CNT_EN adds two saturating 16-bit event
// counters, o_ov_cnt and o_un_cnt. Each counts output handshakes that carried
// the corresponding flag.
//
// state | meaning
// IDLE  | ready for a new operand
// PRE   | classify operand: special / carry / zero / normalised / needs shift
// SHIFT | left-normalise up to SHIFT_STEP positions per cycle
// OUT   | result presented, waiting for i_out_ready
module unit_normalize_seq #(
  parameter int EXP_W      = 8,
  parameter int MANT_W     = 28,
  parameter int SHIFT_STEP = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_in_ready,
  input  logic              i_aos_alu,
  input  logic              i_c_alu,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [MANT_W-1:0] i_mant,
  output logic              o_valid,
  input  logic              i_out_ready,
  output logic [EXP_W-1:0]  o_exp,
  output logic [MANT_W-1:0] o_mant,
  output logic              o_ov_fl,
  output logic              o_un_fl
`ifdef UNIT_NORM_EVT_CNT_EN
  ,
  output logic [15:0]       o_ov_cnt,
  output logic [15:0]       o_un_cnt
`endif
);

  localparam int CNT_W = $clog2(SHIFT_STEP + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, PRE, SHIFT, OUT} state_t;

  state_t            state, state_nxt;
  logic [EXP_W-1:0]  exp_r, exp_nxt;
  logic [MANT_W-1:0] mant_r, mant_nxt;
  logic              aos_r, aos_nxt;
  logic              c_r, c_nxt;
  logic              ov_r, ov_nxt;
  logic              un_r, un_nxt;

  logic [EXP_W-1:0]  exp_inc;
  logic [CNT_W-1:0]  lz;
  logic [EXP_W-1:0]  lz_e;
  logic              lz_found;

  assign exp_inc = exp_r + EXP_W'(1);

  // Leading-zero count over the top SHIFT_STEP mantissa bits only; an all-zero
  // window yields SHIFT_STEP, which keeps the FSM in SHIFT for another pass.
  always_comb begin
    lz       = STEP_MAX;
    lz_found = 1'b0;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (!lz_found && mant_r[MANT_W-1-i]) begin
        lz       = CNT_W'(i);
        lz_found = 1'b1;
      end
    end
    lz_e = EXP_W'(lz);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      exp_r  <= '0;
      mant_r <= '0;
      aos_r  <= 1'b0;
      c_r    <= 1'b0;
      ov_r   <= 1'b0;
      un_r   <= 1'b0;
    end else begin
      state  <= state_nxt;
      exp_r  <= exp_nxt;
      mant_r <= mant_nxt;
      aos_r  <= aos_nxt;
      c_r    <= c_nxt;
      ov_r   <= ov_nxt;
      un_r   <= un_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_r;
    mant_nxt  = mant_r;
    aos_nxt   = aos_r;
    c_nxt     = c_r;
    ov_nxt    = ov_r;
    un_nxt    = un_r;
    case (state)
      IDLE: begin
        if (i_valid) begin
          state_nxt = PRE;
          exp_nxt   = i_exp;
          mant_nxt  = i_mant;
          aos_nxt   = i_aos_alu;
          c_nxt     = i_c_alu;
          ov_nxt    = 1'b0;
          un_nxt    = 1'b0;
        end
      end
      PRE: begin
        state_nxt = OUT;
        if (exp_r == EXP_ONES) begin
          // special operand: pass through untouched
        end else if (!aos_r && c_r) begin
          if (exp_inc == EXP_ONES) begin
            exp_nxt  = EXP_ONES;
            mant_nxt = '0;
            ov_nxt   = 1'b1;
          end else begin
            // the shifted-out bit folds into the sticky bit
            exp_nxt  = exp_inc;
            mant_nxt = {1'b1, mant_r[MANT_W-1:2], mant_r[1] | mant_r[0]};
          end
        end else if (mant_r == '0) begin
          exp_nxt  = '0;
          mant_nxt = '0;
        end else if (mant_r[MANT_W-1]) begin
          // already normalised
        end else begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (exp_r <= lz_e) begin
          exp_nxt   = '0;
          mant_nxt  = '0;
          un_nxt    = 1'b1;
          state_nxt = OUT;
        end else begin
          mant_nxt = mant_r << lz;
          exp_nxt  = exp_r - lz_e;
          if (lz != STEP_MAX) state_nxt = OUT;
        end
      end
      OUT: begin
        if (i_out_ready) begin
          state_nxt = IDLE;
          ov_nxt    = 1'b0;
          un_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_in_ready = (state == IDLE);
  assign o_valid    = (state == OUT);
  assign o_exp      = exp_r;
  assign o_mant     = mant_r;
  assign o_ov_fl    = ov_r;
  assign o_un_fl    = un_r;

`ifdef UNIT_NORM_EVT_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ov_cnt <= '0;
      o_un_cnt <= '0;
    end else if (state == OUT && i_out_ready) begin
      if (ov_r && o_ov_cnt != 16'hFFFF) o_ov_cnt <= o_ov_cnt + 16'd1;
      if (un_r && o_un_cnt != 16'hFFFF) o_un_cnt <= o_un_cnt + 16'd1;
    end
  end
`else
  // no event counters in this build
`endif

endmodule

// File: tb/tb_unit_normalize_seq.sv
module tb_unit_normalize_seq;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_in_ready;
  logic        i_aos_alu;
  logic        i_c_alu;
  logic [7:0]  i_exp;
  logic [27:0] i_mant;
  logic        o_valid;
  logic        i_out_ready;
  logic [7:0]  o_exp;
  logic [27:0] o_mant;
  logic        o_ov_fl;
  logic        o_un_fl;
`ifdef UNIT_NORM_EVT_CNT_EN
  logic [15:0] o_ov_cnt;
  logic [15:0] o_un_cnt;
  int          ov_cnt_m, un_cnt_m;
`endif

  int vectors = 0;
  int miscompares = 0;

  unit_normalize_seq dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_in_ready  (o_in_ready),
    .i_aos_alu   (i_aos_alu),
    .i_c_alu     (i_c_alu),
    .i_exp       (i_exp),
    .i_mant      (i_mant),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_exp       (o_exp),
    .o_mant      (o_mant),
    .o_ov_fl     (o_ov_fl),
    .o_un_fl     (o_un_fl)
`ifdef UNIT_NORM_EVT_CNT_EN
    ,
    .o_ov_cnt    (o_ov_cnt),
    .o_un_cnt    (o_un_cnt)
`endif
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: normalisation result from plain arithmetic on the whole
  // mantissa. A left shift of L positions at 4 per cycle takes L/4+2 cycles;
  // it flushes whenever exp <= L, at the first 4-wide step whose shift would
  // reach the exponent.
  function automatic void ref_model(input int e, input int m, input bit aos, input bit c,
                                    output int re, output int rm, output int rov,
                                    output int run, output int rlat);
    int lzc;
    re = e; rm = m; rov = 0; run = 0; rlat = 1;
    if (e == 255) begin
    end else if (!aos && c) begin
      if (e + 1 == 255) begin
        re = 255; rm = 0; rov = 1;
      end else begin
        re = e + 1;
        rm = (1 << 27) | ((m >> 2) << 1) | (((m & 3) != 0) ? 1 : 0);
      end
    end else if (m == 0) begin
      re = 0; rm = 0;
    end else if (((m >> 27) & 1) == 1) begin
    end else begin
      lzc = 0;
      while (((m >> (27 - lzc)) & 1) == 0) lzc++;
      if (e <= lzc) begin
        re = 0; rm = 0; run = 1;
        if (e == 0) rlat = 2;
        else rlat = (((e + 3) / 4 - 1) < (lzc / 4) ? ((e + 3) / 4 - 1) : (lzc / 4)) + 2;
      end else begin
        re = e - lzc;
        rm = (m << lzc) & 32'h0FFF_FFFF;
        rlat = lzc / 4 + 2;
      end
    end
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_in_ready"}, 32'(o_in_ready), 1);
    chk({tag, "_exp"}, 32'(o_exp), 0);
    chk({tag, "_mant"}, 32'(o_mant), 0);
    chk({tag, "_flags"}, {30'd0, o_ov_fl, o_un_fl}, 0);
  endtask

  task automatic pulse_reset();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
`ifdef UNIT_NORM_EVT_CNT_EN
    ov_cnt_m = 0; un_cnt_m = 0;
`endif
  endtask

  task automatic do_op(input int e, input int m, input bit aos, input bit c, input int hold);
    int re, rm, rov, run, rlat, lat;
    bit got;
    ref_model(e, m, aos, c, re, rm, rov, run, rlat);
    i_exp = 8'(e); i_mant = 28'(m); i_aos_alu = aos; i_c_alu = c; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk("busy_in_ready", 32'(o_in_ready), 0);
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      if (o_valid) got = 1'b1;
      else begin
        @(posedge i_clk); #1;
        lat++;
        if (o_valid) got = 1'b1;
      end
    end
    chk("valid_seen", 32'(got), 1);
    if (!got) begin
      pulse_reset();
      return;
    end
    chk("latency", 32'(lat), 32'(rlat));
    for (int h = 0; h <= hold; h++) begin
      chk("exp", 32'(o_exp), 32'(re));
      chk("mant", 32'(o_mant), 32'(rm));
      chk("ov_fl", 32'(o_ov_fl), 32'(rov));
      chk("un_fl", 32'(o_un_fl), 32'(run));
      chk("out_valid", 32'(o_valid), 1);
      chk("stall_in_ready", 32'(o_in_ready), 0);
      if (h < hold) begin
        @(posedge i_clk); #1;
      end
    end
    i_out_ready = 1'b1;
    @(posedge i_clk); #1;
    i_out_ready = 1'b0;
    chk("post_valid", 32'(o_valid), 0);
    chk("post_in_ready", 32'(o_in_ready), 1);
    chk("post_flags", {30'd0, o_ov_fl, o_un_fl}, 0);
`ifdef UNIT_NORM_EVT_CNT_EN
    if (rov == 1) ov_cnt_m++;
    if (run == 1) un_cnt_m++;
    chk("ov_cnt", 32'(o_ov_cnt), 32'(ov_cnt_m));
    chk("un_cnt", 32'(o_un_cnt), 32'(un_cnt_m));
`endif
  endtask

  initial begin
    int e, m, lz, sel, top;
    i_rst = 1'b1; i_valid = 1'b0; i_out_ready = 1'b0;
    i_aos_alu = 1'b0; i_c_alu = 1'b0; i_exp = '0; i_mant = '0;
    @(posedge i_clk); #1;
    pulse_reset();
    check_idle("reset");

    do_op(8'h80, 28'h8000000, 1'b1, 1'b0, 0);
    do_op(8'h80, 28'h0000003, 1'b0, 1'b1, 0);
    do_op(8'hFE, 28'h0000003, 1'b0, 1'b1, 0);
    do_op(8'h80, 28'h0100000, 1'b1, 1'b0, 0);
    do_op(8'h80, 28'h0000000, 1'b1, 1'b0, 0);
    do_op(8'h03, 28'h0100000, 1'b1, 1'b0, 0);
    do_op(8'hFF, 28'h1234567, 1'b0, 1'b1, 0);
    do_op(8'h80, 28'h0800000, 1'b1, 1'b0, 5);
    do_op(8'h04, 28'h0800000, 1'b1, 1'b0, 0);
    do_op(8'h08, 28'h0800000, 1'b1, 1'b0, 0);
    do_op(8'h05, 28'h0800000, 1'b1, 1'b0, 0);
    do_op(8'h00, 28'h4000000, 1'b0, 1'b0, 0);
    do_op(8'hFE, 28'h0000001, 1'b0, 1'b1, 1);
    do_op(8'h40, 28'h0000001, 1'b0, 1'b0, 0);

    // reset while in SHIFT discards the operand
    i_exp = 8'h80; i_mant = 28'h0000100; i_aos_alu = 1'b1; i_c_alu = 1'b0; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("shift_busy", 32'(o_in_ready), 0);
    pulse_reset();
    check_idle("mid_reset");
`ifdef UNIT_NORM_EVT_CNT_EN
    chk("ov_cnt_rst", 32'(o_ov_cnt), 0);
`endif

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: e = 255;
        1: e = 254;
        2, 3: e = $urandom_range(0, 12);
        default: e = $urandom_range(0, 254);
      endcase
      if ($urandom_range(0, 15) == 0) m = 0;
      else begin
        lz = $urandom_range(0, 27);
        top = 1 << (27 - lz);
        m = top | int'($urandom() & 32'(top - 1));
      end
      do_op(e, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unit_normalize_seq.md
Name: unit_normalize_seq

Overview:
Iterative, handshaked normaliser for the FPU add/sub datapath. It is the parametrised successor of the single-cycle combinational normaliser.
- Takes the raw ALU exponent/mantissa, carry and add/sub flag.
- Resolves carry right-shift, special (all-ones exponent), zero, left-normalisation and under/overflow.
- Left shifts are performed at up to SHIFT_STEP bit positions per cycle, to bound the critical path.
- Sits between the mantissa ALU and the rounding stage; valid/ready on both sides.

Parameters:
EXP_W, 8, exponent width; all-ones exponent = special.
MANT_W, 28, mantissa width; bit MANT_W-1 = hidden bit; bit 0 = sticky.
SHIFT_STEP, 4, max left-shift positions per cycle; power of two, 1..MANT_W-1.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_valid  in  1  input operand valid
o_in_ready  out  1  block can accept; high only in IDLE
i_aos_alu  in  1  0 = add, 1 = subtract; carry honoured only when 0
i_c_alu  in  1  ALU carry-out
i_exp  in  EXP_W  raw exponent
i_mant  in  MANT_W  raw mantissa
o_valid  out  1  result valid
i_out_ready  in  1  downstream accepts
o_exp  out  EXP_W  normalised exponent
o_mant  out  MANT_W  normalised mantissa
o_ov_fl  out  1  overflow
o_un_fl  out  1  underflow (flushed to zero)

Behaviour:
- Clock and reset: one clock i_clk. i_rst is synchronous and active-high.
- Reset values: state IDLE; o_valid=0; o_exp=0; o_mant=0; o_ov_fl=0; o_un_fl=0; o_in_ready=1 in the cycle after reset.
- Reset mid-operation: any state returns to IDLE; the in-flight operand is discarded; no o_valid.
- FSM states: IDLE, PRE, SHIFT, OUT.
- IDLE: o_in_ready=1. On i_valid, register the inputs and go to PRE.
- PRE: first matching case wins, in this priority order:
  1. Special: exp all-ones. Pass exp/mant through unchanged, flags 0, go to OUT.
  2. Carry (i_aos_alu=0 and i_c_alu=1): mant = {1, mant[MANT_W-1:2], mant[1]|mant[0]}; exp+1. If exp+1 is all-ones, force exp all-ones, mant 0, o_ov_fl=1. Go to OUT.
  3. Zero: mant==0. Exp 0, mant 0, flags 0, go to OUT.
  4. Normalised: mant[MANT_W-1]=1. Unchanged, go to OUT.
  5. Otherwise go to SHIFT.
- SHIFT: n = leading-zero count of the top SHIFT_STEP mantissa bits, capped at SHIFT_STEP.
  - If exp_reg <= n: flush. Exp 0, mant 0, o_un_fl=1, go to OUT.
  - Else mant <<= n (zero fill) and exp -= n.
  - Stay in SHIFT if n==SHIFT_STEP; otherwise go to OUT.
- OUT: o_valid=1. Outputs and flags are held stable while i_out_ready=0. On i_out_ready, go to IDLE and drop o_valid.
- Throughput: at most one operation in flight; no new acceptance until the OUT handshake completes.
- Latency, counted from the acceptance edge to the first cycle o_valid is high:
  - special, carry, zero or already normalised: 1 cycle;
  - left shift of L positions: floor(L/SHIFT_STEP)+2 cycles.
- Width rules: exponent arithmetic is unsigned EXP_W bits; carry increment and left-shift decrement never wrap because of the overflow/underflow checks above.
- Flags: o_ov_fl and o_un_fl are mutually exclusive and meaningful only while o_valid=1; they are cleared on leaving OUT.

Optional Feature:
UNIT_NORM_EVT_CNT_EN
- Defined: adds outputs o_ov_cnt[15:0] and o_un_cnt[15:0].
  - Each counter increments by 1 on an OUT handshake whose o_ov_fl (resp. o_un_fl) is 1.
  - Counters saturate at 0xFFFF and are reset to 0 by i_rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
All scenarios use defaults EXP_W=8, MANT_W=28, SHIFT_STEP=4.
- Normalised pass-through: exp 0x80, mant 0x8000000, aos=1 -> exp 0x80, mant 0x8000000, flags 0, o_valid 1 cycle after acceptance.
- Carry: aos=0, c=1, exp 0x80, mant 0x0000003 -> exp 0x81, mant 0x8000001, 1 cycle. Same with exp 0xFE -> exp 0xFF, mant 0, o_ov_fl=1.
- Left shift: exp 0x80, mant 0x0100000 (L=7) -> exp 0x79, mant 0x8000000, o_valid 3 cycles after acceptance. Same with mant 0 -> exp 0, mant 0, flags 0.
- Underflow: exp 0x03, mant 0x0100000 -> exp 0, mant 0, o_un_fl=1.
- Special: exp 0xFF, mant 0x1234567, c=1 -> exp 0xFF, mant 0x1234567, flags 0.
- Handshake and reset:
  - Hold i_out_ready=0 for 5 cycles: outputs stable, o_in_ready=0 throughout.
  - Assert i_rst during SHIFT: next cycle IDLE, o_valid=0, all outputs 0.
  - With UNIT_NORM_EVT_CNT_EN: two overflow handshakes -> o_ov_cnt=2.
